// File: rtl/mandel_line_buffer_if.sv
// Write-side handshake between the Mandelbrot core and the line buffer.
// The core drives a pixel (iteration count plus end-of-line flag) and the buffer answers with ready.
interface mandel_line_buffer_if #(
    parameter int ITER_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ITER_W-1:0] wr_iter;
    logic              wr_last;

    modport master (
        output wr_valid,
        output wr_iter,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_iter,
        input  wr_last,
        output wr_ready
    );
endinterface

// File: rtl/mandel_line_buffer.sv
// Ping-pong line buffer and colour mapper between the Mandelbrot core and the VGA generator.
// Optional palette RAM: define MANDEL_PALETTE_RAM_EN (otherwise a fixed colour map is used).
module mandel_line_buffer #(
    parameter int          H_RES     = 640,
    parameter int          ITER_W    = 8,
    parameter int          MAX_ITER  = 255,
    parameter logic [29:0] UNDER_RGB = 30'h3FF00000
) (
    input  logic                fpga_clk,
    input  logic                fpga_reset,
    mandel_line_buffer_if.slave wr,
    input  logic [10:0]         pixel_x,
    input  logic [10:0]         pixel_y,
    output logic [9:0]          pd_r,
    output logic [9:0]          pd_g,
    output logic [9:0]          pd_b,
    output logic                underrun,
    input  logic                underrun_clr,
    input  logic                pal_we,
    input  logic [7:0]          pal_addr,
    input  logic [29:0]         pal_data
);
    localparam int WP_W = $clog2(H_RES);
    localparam int A_W  = $clog2(2 * H_RES);

    function automatic logic [29:0] fixed_map(input logic [7:0] i);
        return {i, 2'b00, i[6:0], 3'b000, ~i, 2'b11};
    endfunction

    logic              wb_q, wb_d;
    logic [WP_W-1:0]   wp_q, wp_d;
    logic [1:0]        full_q, full_d;
    logic [10:0]       prev_y_q;
    logic              accept, line_done, release_en;

    logic [ITER_W-1:0] mem [2*H_RES];
    logic [A_W-1:0]    waddr, raddr;
    logic              rb, in_range;

    logic [ITER_W-1:0] rd_iter_q;
    logic              s1_inr_q, s1_full_q;

    logic [29:0]       pal_rgb;
    logic              blank;
    logic [29:0]       rgb_d, rgb_q;
    logic              ur_set, ur_q;

    // Ready reflects registered bank state only; held low while in reset.
    assign wr.wr_ready = ~full_q[wb_q] & ~fpga_reset;
    assign accept      = wr.wr_valid & wr.wr_ready;
    assign line_done   = wr.wr_last | (wp_q == WP_W'(H_RES - 1));
    assign release_en  = pixel_y != prev_y_q;

    // Bank bookkeeping: release on a line change, then a completing write sets (set wins).
    always_comb begin
        wb_d   = wb_q;
        wp_d   = wp_q;
        full_d = full_q;
        if (release_en) begin
            full_d[prev_y_q[0]] = 1'b0;
        end
        if (accept) begin
            if (line_done) begin
                wp_d         = '0;
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end else begin
                wp_d = wp_q + WP_W'(1);
            end
        end
    end

    // Write pointer, bank select, full flags and previous display row.
    always_ff @(posedge fpga_clk) begin
        if (fpga_reset) begin
            wb_q     <= 1'b0;
            wp_q     <= '0;
            full_q   <= '0;
            prev_y_q <= '0;
        end else begin
            wb_q     <= wb_d;
            wp_q     <= wp_d;
            full_q   <= full_d;
            prev_y_q <= pixel_y;
        end
    end

    assign waddr    = wb_q ? A_W'(H_RES) + A_W'(wp_q) : A_W'(wp_q);
    assign rb       = pixel_y[0];
    assign in_range = pixel_x < 11'(H_RES);
    assign raddr    = !in_range ? '0
                    : rb ? A_W'(H_RES) + A_W'(pixel_x) : A_W'(pixel_x);

    // Line RAM write port.
    always_ff @(posedge fpga_clk) begin
        if (accept) begin
            mem[waddr] <= wr.wr_iter;
        end
    end

    // Registered line RAM read port (stage 1 data).
    always_ff @(posedge fpga_clk) begin
        rd_iter_q <= mem[raddr];
    end

    // Stage 1 qualifiers travelling with the RAM read.
    always_ff @(posedge fpga_clk) begin
        if (fpga_reset) begin
            s1_inr_q  <= 1'b0;
            s1_full_q <= 1'b0;
        end else begin
            s1_inr_q  <= in_range;
            s1_full_q <= full_q[rb];
        end
    end

`ifdef MANDEL_PALETTE_RAM_EN
    logic [29:0] pal_mem [256];
    logic [7:0]  walk_q;
    logic        walking_q;

    // Init walk counter: reloads the fixed map into the palette after reset.
    always_ff @(posedge fpga_clk) begin
        if (fpga_reset) begin
            walk_q    <= '0;
            walking_q <= 1'b1;
        end else if (walking_q) begin
            walk_q <= walk_q + 8'd1;
            if (walk_q == 8'hFF) begin
                walking_q <= 1'b0;
            end
        end
    end

    // Palette write port shared by the init walk and the host.
    always_ff @(posedge fpga_clk) begin
        if (!fpga_reset && walking_q) begin
            pal_mem[walk_q] <= fixed_map(walk_q);
        end else if (!fpga_reset && pal_we) begin
            pal_mem[pal_addr] <= pal_data;
        end
    end

    assign pal_rgb = pal_mem[rd_iter_q[7:0]];
    assign blank   = walking_q;
`else
    logic unused_pal;

    assign unused_pal = ^{pal_we, pal_addr, pal_data};
    assign pal_rgb    = fixed_map(rd_iter_q[7:0]);
    assign blank      = 1'b0;
`endif

    // Stage 2 colour selection in priority order.
    always_comb begin
        rgb_d  = '0;
        ur_set = 1'b0;
        if (blank || !s1_inr_q) begin
            rgb_d = '0;
        end else if (!s1_full_q) begin
            rgb_d  = UNDER_RGB;
            ur_set = 1'b1;
        end else if (rd_iter_q == ITER_W'(MAX_ITER)) begin
            rgb_d = '0;
        end else begin
            rgb_d = pal_rgb;
        end
    end

    // Stage 2 output registers and sticky underrun flag (set beats clear).
    always_ff @(posedge fpga_clk) begin
        if (fpga_reset) begin
            rgb_q <= '0;
            ur_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            ur_q  <= ur_set | (ur_q & ~underrun_clr);
        end
    end

    assign pd_r     = rgb_q[29:20];
    assign pd_g     = rgb_q[19:10];
    assign pd_b     = rgb_q[9:0];
    assign underrun = ur_q;
endmodule
